mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address and data bus width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 16, meaning the memory holds 2^DEPTH_LOG2 words; legal addresses are 0..2^DEPTH_LOG2-1.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fetch_req  input  1  instruction fetch request, held until fetch_ack.
REQ-006 SHALL have port pc  input  32  fetch address.
REQ-007 SHALL have port fetch_ack  output  1  one-cycle pulse, instr valid.
REQ-008 SHALL have port instr  output  32  fetched instruction.
REQ-009 SHALL have port data_req  input  1  load/store request, held until data_ack.
REQ-010 SHALL have port data_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port data_addr  input  32  load/store address.
REQ-012 SHALL have port data_wdata  input  32  store data.
REQ-013 SHALL have port data_ack  output  1  one-cycle completion pulse.
REQ-014 SHALL have port data_rdata  output  32  load result.
REQ-015 SHALL have port addr_err  output  1  one-cycle pulse with the ack of an out-of-range access.
REQ-016 SHALL have port mem_addr  output  32  memory address.
REQ-017 SHALL have port mem_rw  output  2  01 read, 10 write, 00 fetch.
REQ-018 SHALL have port mem_din  output  32  memory write data.
REQ-019 SHALL have port mem_enable  output  1  memory access strobe.
REQ-020 SHALL have ports mem_dout and mem_fetch  input  32 each  memory read and fetch data.

Function
REQ-021 SHALL implement FSM states IDLE, ACCESS, CAPTURE.
REQ-022 In IDLE with any request pending, SHALL grant one request, latch its address, write data and kind, and go to ACCESS.
REQ-023 When both requests are pending, SHALL grant the one not granted last; after reset, data has priority.
REQ-024 In ACCESS, SHALL drive mem_enable=1, mem_addr=latched address, mem_rw per the kind, and mem_din=latched write data for exactly one cycle, then go to CAPTURE.
REQ-025 In CAPTURE, SHALL register mem_fetch into instr (fetch) or mem_dout into data_rdata (load), pulse the matching ack, and return to IDLE.
REQ-026 Latency SHALL be 3 cycles: request sampled in IDLE at edge N, ack high during cycle N+2, next grant at edge N+3 at the earliest.
REQ-027 A store SHALL leave data_rdata unchanged; a fetch SHALL leave data_rdata unchanged; a load SHALL leave instr unchanged.
REQ-028 An out-of-range latched address (any bit at or above DEPTH_LOG2 set) SHALL keep mem_enable=0 in ACCESS, return 0 data for loads and fetches, and pulse addr_err with the ack.
REQ-029 Outside ACCESS, mem_enable SHALL be 0, mem_rw SHALL be 00, and mem_addr and mem_din SHALL hold their last values.
REQ-030 Requester inputs SHALL be sampled only at grant; later changes SHALL NOT affect the access in flight.
REQ-031 A request deasserted before grant SHALL be dropped without any memory access.

Reset
REQ-032 While reset_n=0, SHALL force state IDLE, fetch_ack=0, data_ack=0, addr_err=0, mem_enable=0, mem_rw=00, and zero on instr, data_rdata, mem_addr and mem_din, with priority reset to data.
REQ-033 A reset asserted during ACCESS or CAPTURE SHALL abort the access with no ack, and the requester SHALL re-issue it.

Structure
REQ-034 A shared package mem_pkg SHALL hold the rw encodings RW_FETCH, RW_READ and RW_WRITE, the FSM state enum, and the DEPTH_LOG2 default.
REQ-035 The grant logic SHALL be the sub-module mem_arb, a two-way round-robin arbiter with a registered last-grant flag.

Verification
REQ-036 Fetch: pc=0x10, mem_fetch=0xDEADBEEF -> mem_rw=00 with enable during ACCESS; instr=0xDEADBEEF; fetch_ack pulses 2 cycles after the request is sampled.
REQ-037 Store then load at 0x20 with 0x12345678 -> a write strobe with mem_rw=10 and mem_din=0x12345678; the load then returns data_rdata=0x12345678.
REQ-038 fetch_req and data_req held together for 4 transactions -> order data, fetch, data, fetch.
REQ-039 Load from 0x00010000 -> mem_enable stays 0; data_rdata=0; addr_err and data_ack pulse together.
REQ-040 reset_n dropped during ACCESS -> outputs reach their reset values immediately, no ack; after release, the held request completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory master: bus rw encodings, FSM states, default memory depth.
package mem_pkg;

   localparam int DEPTH_LOG2_DEF = 16;

   typedef enum logic [1:0] {
      RW_FETCH = 2'b00,
      RW_READ  = 2'b01,
      RW_WRITE = 2'b10
   } rw_e;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ACCESS  = 2'b01,
      CAPTURE = 2'b10
   } state_e;

endpackage

// File: rtl/mem_master_if.sv
// Requester and memory-side signals of the memory master, bundled for port connection.
interface mem_master_if #(
   parameter int ADDR_W = 32
) ();

   logic              fetch_req;
   logic [ADDR_W-1:0] pc;
   logic              fetch_ack;
   logic [ADDR_W-1:0] instr;

   logic              data_req;
   logic              data_we;
   logic [ADDR_W-1:0] data_addr;
   logic [ADDR_W-1:0] data_wdata;
   logic              data_ack;
   logic [ADDR_W-1:0] data_rdata;
   logic              addr_err;

   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_rw;
   logic [ADDR_W-1:0] mem_din;
   logic              mem_enable;
   logic [ADDR_W-1:0] mem_dout;
   logic [ADDR_W-1:0] mem_fetch;

   modport master (
      input  fetch_req, pc, data_req, data_we, data_addr, data_wdata, mem_dout, mem_fetch,
      output fetch_ack, instr, data_ack, data_rdata, addr_err,
             mem_addr, mem_rw, mem_din, mem_enable
   );

   modport slave (
      output fetch_req, pc, data_req, data_we, data_addr, data_wdata, mem_dout, mem_fetch,
      input  fetch_ack, instr, data_ack, data_rdata, addr_err,
             mem_addr, mem_rw, mem_din, mem_enable
   );

endinterface

// File: rtl/mem_arb.sv
// Two-way round-robin arbiter between fetch and data requesters; data wins the first tie after reset.
module mem_arb (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   input  logic fetch_req_i,
   input  logic data_req_i,
   output logic gnt_fetch_o,
   output logic gnt_data_o
);

   logic prio_data_q, prio_data_d;

   always_comb begin
      gnt_fetch_o = 1'b0;
      gnt_data_o  = 1'b0;
      if (en_i) begin
         if (data_req_i && (prio_data_q || !fetch_req_i)) begin
            gnt_data_o = 1'b1;
         end else if (fetch_req_i) begin
            gnt_fetch_o = 1'b1;
         end
      end
   end

   always_comb begin
      prio_data_d = prio_data_q;
      if (gnt_data_o) begin
         prio_data_d = 1'b0;
      end else if (gnt_fetch_o) begin
         prio_data_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prio_data_q <= 1'b1;
      end else begin
         prio_data_q <= prio_data_d;
      end
   end

endmodule

// File: rtl/mem_master.sv
// Single-port memory master serving an instruction-fetch and a load/store requester.
// state   | meaning
// IDLE    | waiting for a request; arbiter grants one and its fields are latched
// ACCESS  | one-cycle memory strobe with the latched address/kind/data
// CAPTURE | memory result registered, ack (and addr_err) pulsed on exit
module mem_master
   import mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   mem_master_if.master bus
);

   state_e            state_q, state_d;
   rw_e               kind_q, kind_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] rdata_q, rdata_d;
   logic              fetch_ack_q, fetch_ack_d;
   logic              data_ack_q, data_ack_d;
   logic              addr_err_q, addr_err_d;

   logic gnt_fetch, gnt_data, in_range;
   logic mem_enable;
   rw_e  mem_rw;

   mem_arb u_arb (
      .clk         (clk),
      .reset_n     (reset_n),
      .en_i        (state_q == IDLE),
      .fetch_req_i (bus.fetch_req),
      .data_req_i  (bus.data_req),
      .gnt_fetch_o (gnt_fetch),
      .gnt_data_o  (gnt_data)
   );

   if (DEPTH_LOG2 >= ADDR_W) begin : g_full_range
      assign in_range = 1'b1;
   end else begin : g_part_range
      assign in_range = (addr_q[ADDR_W-1:DEPTH_LOG2] == '0);
   end

   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      instr_d     = instr_q;
      rdata_d     = rdata_q;
      fetch_ack_d = 1'b0;
      data_ack_d  = 1'b0;
      addr_err_d  = 1'b0;
      mem_enable  = 1'b0;
      mem_rw      = RW_FETCH;
      case (state_q)
         IDLE: begin
            if (gnt_data) begin
               addr_d  = bus.data_addr;
               wdata_d = bus.data_wdata;
               kind_d  = bus.data_we ? RW_WRITE : RW_READ;
               state_d = ACCESS;
            end else if (gnt_fetch) begin
               addr_d  = bus.pc;
               kind_d  = RW_FETCH;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            mem_enable = in_range;
            mem_rw     = kind_q;
            state_d    = CAPTURE;
         end
         CAPTURE: begin
            addr_err_d = !in_range;
            state_d    = IDLE;
            case (kind_q)
               RW_FETCH: begin
                  fetch_ack_d = 1'b1;
                  instr_d     = in_range ? bus.mem_fetch : '0;
               end
               RW_READ: begin
                  data_ack_d = 1'b1;
                  rdata_d    = in_range ? bus.mem_dout : '0;
               end
               default: begin
                  data_ack_d = 1'b1;
               end
            endcase
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         kind_q      <= RW_FETCH;
         addr_q      <= '0;
         wdata_q     <= '0;
         instr_q     <= '0;
         rdata_q     <= '0;
         fetch_ack_q <= 1'b0;
         data_ack_q  <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         instr_q     <= instr_d;
         rdata_q     <= rdata_d;
         fetch_ack_q <= fetch_ack_d;
         data_ack_q  <= data_ack_d;
         addr_err_q  <= addr_err_d;
      end
   end

   // Address and write data are only reloaded at grant, so they hold outside ACCESS.
   assign bus.mem_addr   = addr_q;
   assign bus.mem_din    = wdata_q;
   assign bus.mem_enable = mem_enable;
   assign bus.mem_rw     = mem_rw;
   assign bus.fetch_ack  = fetch_ack_q;
   assign bus.data_ack   = data_ack_q;
   assign bus.addr_err   = addr_err_q;
   assign bus.instr      = instr_q;
   assign bus.data_rdata = rdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed and randomized bench for mem_master with a synchronous memory device and a reference model.
module tb_mem_master;
   import mem_pkg::*;

   localparam int AW = 32;
   localparam int DL = 16;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mem_master_if #(.ADDR_W(AW)) bus ();

   mem_master #(.ADDR_W(AW), .DEPTH_LOG2(DL)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.master)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [31:0] seed_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   // Memory device: untouched words read back a fixed hash of their address.
   logic [31:0] dev_wr [int unsigned];
   int unsigned en_cnt = 0;
   logic [1:0]  last_rw;
   logic [31:0] last_addr, last_din;

   function automatic logic [31:0] dev_word(input logic [31:0] a);
      return dev_wr.exists(a) ? dev_wr[a] : seed_word(a);
   endfunction

   always @(posedge clk) begin
      if (bus.mem_enable) begin
         en_cnt    <= en_cnt + 1;
         last_rw   <= bus.mem_rw;
         last_addr <= bus.mem_addr;
         last_din  <= bus.mem_din;
         case (bus.mem_rw)
            2'b10:   dev_wr[bus.mem_addr] = bus.mem_din;
            2'b01:   bus.mem_dout  <= dev_word(bus.mem_addr);
            default: bus.mem_fetch <= dev_word(bus.mem_addr);
         endcase
      end
   end

   // Reference model: expected memory contents and expected output registers.
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] exp_instr, exp_rdata;

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_fetch_ack"}, 32'(bus.fetch_ack), 0);
      chk({tag, "_data_ack"}, 32'(bus.data_ack), 0);
      chk({tag, "_addr_err"}, 32'(bus.addr_err), 0);
      chk({tag, "_mem_enable"}, 32'(bus.mem_enable), 0);
      chk({tag, "_mem_rw"}, 32'(bus.mem_rw), 0);
      chk({tag, "_instr"}, bus.instr, 0);
      chk({tag, "_rdata"}, bus.data_rdata, 0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_mem_din"}, bus.mem_din, 0);
   endtask

   // kind: 0 fetch, 1 load, 2 store. Issued with the DUT idle.
   task automatic single(input int kind, input logic [31:0] addr, input logic [31:0] wd);
      bit          inr, seen;
      int          cyc, exp_rw;
      int unsigned en0;
      logic        other;
      inr    = (addr < (32'd1 << DL));
      exp_rw = (kind == 0) ? 0 : (kind == 1) ? 1 : 2;
      en0    = en_cnt;
      @(negedge clk);
      if (kind == 0) begin
         bus.fetch_req = 1'b1;
         bus.pc        = addr;
      end else begin
         bus.data_req   = 1'b1;
         bus.data_we    = (kind == 2);
         bus.data_addr  = addr;
         bus.data_wdata = wd;
      end
      cyc   = 0;
      seen  = 1'b0;
      other = 1'b0;
      while (!seen && cyc < 12) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            bus.pc         = $urandom;
            bus.data_addr  = $urandom;
            bus.data_wdata = $urandom;
            bus.data_we    = 1'($urandom_range(0, 1));
         end
         seen  = (kind == 0) ? bus.fetch_ack : bus.data_ack;
         other = other | ((kind == 0) ? bus.data_ack : bus.fetch_ack);
      end
      bus.fetch_req = 1'b0;
      bus.data_req  = 1'b0;
      if (kind == 0) exp_instr = inr ? ref_read(addr) : 32'h0;
      if (kind == 1) exp_rdata = inr ? ref_read(addr) : 32'h0;
      if (kind == 2 && inr) ref_mem[addr] = wd;
      chk("ack_seen", 32'(seen), 1);
      chk("latency", cyc, 3);
      chk("other_ack", 32'(other), 0);
      chk("instr", bus.instr, exp_instr);
      chk("rdata", bus.data_rdata, exp_rdata);
      chk("addr_err", 32'(bus.addr_err), 32'(!inr));
      chk("strobes", en_cnt - en0, 32'(inr));
      chk("idle_enable", 32'(bus.mem_enable), 0);
      chk("idle_rw", 32'(bus.mem_rw), 0);
      chk("hold_addr", bus.mem_addr, addr);
      if (inr) begin
         chk("strobe_rw", 32'(last_rw), exp_rw);
         chk("strobe_addr", last_addr, addr);
         if (kind == 2) chk("strobe_din", last_din, wd);
      end
   endtask

   initial begin
      int          got, cyc, dack_cnt;
      int unsigned en0;
      bit          seen;

      bus.fetch_req  = 1'b0;
      bus.pc         = '0;
      bus.data_req   = 1'b0;
      bus.data_we    = 1'b0;
      bus.data_addr  = '0;
      bus.data_wdata = '0;
      exp_instr      = '0;
      exp_rdata      = '0;
      reset_n        = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("por");
      reset_n = 1'b1;

      // Both requesters held: grants must alternate, data first after reset.
      @(negedge clk);
      bus.fetch_req  = 1'b1;
      bus.pc         = 32'h30;
      bus.data_req   = 1'b1;
      bus.data_we    = 1'b0;
      bus.data_addr  = 32'h31;
      for (int k = 0; k < 4; k++) begin
         got = 0;
         cyc = 0;
         while (got == 0 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (bus.data_ack && bus.fetch_ack) got = 3;
            else if (bus.data_ack) got = 1;
            else if (bus.fetch_ack) got = 2;
         end
         chk($sformatf("arb_order_%0d", k), got, (k % 2 == 0) ? 1 : 2);
      end
      bus.fetch_req = 1'b0;
      bus.data_req  = 1'b0;
      exp_instr = ref_read(32'h30);
      exp_rdata = ref_read(32'h31);
      chk("arb_instr", bus.instr, exp_instr);
      chk("arb_rdata", bus.data_rdata, exp_rdata);

      // Store/load round trip and fetch of a stored word.
      single(2, 32'h20, 32'h1234_5678);
      single(1, 32'h20, 32'h0);
      chk("load_12345678", bus.data_rdata, 32'h1234_5678);
      single(2, 32'h10, 32'hDEAD_BEEF);
      single(0, 32'h10, 32'h0);
      chk("fetch_deadbeef", bus.instr, 32'hDEAD_BEEF);
      chk("fetch_kept_rdata", bus.data_rdata, 32'h1234_5678);

      // Range boundaries.
      single(1, 32'h0001_0000, 32'h0);
      single(2, 32'h0000_FFFF, 32'hA5A5_0F0F);
      single(1, 32'h0000_FFFF, 32'h0);
      single(0, 32'h8000_0000, 32'h0);
      single(2, 32'h0002_0020, 32'hCAFE_F00D);
      single(1, 32'h20, 32'h0);

      // A data request withdrawn before it can be granted must vanish.
      en0 = en_cnt;
      @(negedge clk);
      bus.fetch_req = 1'b1;
      bus.pc        = 32'h40;
      @(negedge clk);
      bus.data_req   = 1'b1;
      bus.data_we    = 1'b1;
      bus.data_addr  = 32'h41;
      bus.data_wdata = $urandom;
      @(negedge clk);
      bus.data_req = 1'b0;
      @(negedge clk);
      chk("drop_fetch_ack", 32'(bus.fetch_ack), 1);
      bus.fetch_req = 1'b0;
      exp_instr = ref_read(32'h40);
      dack_cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.data_ack) dack_cnt++;
      end
      chk("drop_no_ack", dack_cnt, 0);
      chk("drop_strobes", en_cnt - en0, 1);
      chk("drop_instr", bus.instr, exp_instr);
      single(1, 32'h41, 32'h0);

      for (int i = 0; i < 40; i++) begin
         int          kind;
         logic [31:0] a;
         kind = $urandom_range(0, 2);
         if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0001_0000;
         else a = 32'($urandom_range(0, 31));
         single(kind, a, $urandom);
      end

      // Reset during ACCESS aborts the load; the held request completes afterwards.
      @(negedge clk);
      bus.data_req  = 1'b1;
      bus.data_we   = 1'b0;
      bus.data_addr = 32'h20;
      @(posedge clk);
      #2;
      chk("pre_rst_enable", 32'(bus.mem_enable), 1);
      reset_n = 1'b0;
      #1;
      check_reset_vals("mid");
      exp_instr = '0;
      exp_rdata = '0;
      dack_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.data_ack || bus.fetch_ack) dack_cnt++;
      end
      chk("rst_no_ack", dack_cnt, 0);
      reset_n = 1'b1;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 12) begin
         @(negedge clk);
         cyc++;
         seen = bus.data_ack;
      end
      bus.data_req = 1'b0;
      exp_rdata = ref_read(32'h20);
      chk("rst_reissue_ack", 32'(seen), 1);
      chk("rst_reissue_latency", cyc, 3);
      chk("rst_reissue_rdata", bus.data_rdata, exp_rdata);
      chk("rst_reissue_instr", bus.instr, exp_instr);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
